if_inst_queue: RTL and testbench
================================

# if_inst_queue

Instruction queue between the fetch (PC/IF) stage and the decode stage. It buffers up to `DEPTH` fetched instruction bundles (pc, instruction word, delay-slot flag, exception vector) so that decode back-pressure does not throttle the icache. Fetch sees a single `iq_stall_o` line that feeds its `if_stall_i` path. Decode pops bundles with a valid/ready handshake.

## Interface
- `DEPTH`, 4: number of entries; power of two, at least 2.
- `EXC_W`, `` `ExcE_W ``: width of the exception vector.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush_i` input 1: from controller; discard all queued and incoming bundles.
- `wr_valid_i` input 1: fetch bundle valid (fetch `pcvalid`).
- `wr_pc_i` input 32: fetch pc.
- `wr_inst_i` input 32: fetch instruction word.
- `wr_inslot_i` input 1: bundle is in a delay slot.
- `wr_excs_i` input EXC_W: fetch exception vector.
- `wr_has_exc_i` input 1: any fetch exception.
- `iq_stall_o` output 1: queue full; fetch must hold its bundle.
- `rd_valid_o` output 1: head bundle valid.
- `rd_ready_i` input 1: decode accepts the head bundle this cycle.
- `rd_pc_o` output 32, `rd_inst_o` output 32, `rd_inslot_o` output 1, `rd_excs_o` output EXC_W, `rd_has_exc_o` output 1: head bundle fields.
- `iq_count_o` output log2(DEPTH)+1: occupancy, for debug and performance counters.

## Operation
- Circular buffer with registered `head`, `tail` (log2(DEPTH) bits, natural wrap) and `count` (log2(DEPTH)+1 bits).
- Write fire (`wf`) = `wr_valid_i & !full & !flush_i`, where `full = (count == DEPTH)`. The bundle is stored at `tail` and `tail` increments.
- Read fire (`rf`) = `rd_valid_o & rd_ready_i & !flush_i`. `head` increments.
- `count` update: +1 on wf only, −1 on rf only, unchanged when both fire or neither fires.
- `iq_stall_o = full`. It depends only on registered state, with no combinational path from `rd_ready_i`. When the queue is full and a read fires, the write is still refused that cycle and is accepted on the next one.
- `rd_valid_o = (count != 0)`. Outputs are driven from the entry at `head`. When `rd_valid_o` is 0, the data outputs read as 0.
- `flush_i` has priority over everything. Next cycle: `head = tail = count = 0`, and any same-cycle write or read is ignored.
- Empty queue with a read request: no effect.
- A bundle with `wr_valid_i=0` is never stored, even if the fields are non-zero.

## Timing
- Reset (`rst`=1 at an edge): `head`, `tail` and `count` are 0. In the following cycle `rd_valid_o=0`, `iq_stall_o=0`, `iq_count_o=0`, and all `rd_*` data outputs are 0. Entry storage itself is not reset.
- A reset in mid-operation behaves identically to a flush and drops all entries.
- Latency without bypass: a bundle written at edge N is visible on `rd_*` in the cycle after edge N and can be consumed at edge N+1.
- Throughput: one write and one read per cycle, sustained.
- A flush asserted in the same cycle as a write: the bundle is lost. Fetch re-issues from the flush pc.

## Configuration
- `IQ_BYPASS_EN` defined: when `count==0`, `wr_valid_i=1`, `rd_ready_i=1` and `flush_i=0`, the incoming bundle drives `rd_*` combinationally and `rd_valid_o=1`. The bundle is consumed without being enqueued, so `count` stays 0 and the latency is 0 cycles. In that case `rd_valid_o = (count!=0) | wr_valid_i`, and when `count==0` the `rd_*` fields mux from `wr_*`.
- `IQ_BYPASS_EN` undefined: the behaviour is purely registered, as described above, with a minimum latency of 1 cycle.

## Structure
- The shared defines header holds:
  - `` `ExcE_W ``
  - the bundle width constant `IQ_BUNDLE_W = 32+32+1+1+EXC_W`
  - the field offset macros used to pack and unpack the bundle.
- One sub-module: `iq_ram`. It is a DEPTH×IQ_BUNDLE_W register array with one synchronous write port and one asynchronous read port. Pointer and count logic stays in the top module.

## Test plan
- Reset, then write pc=0xbfc00000 and inst=0x3c1d8000 with `rd_ready_i=0` → next cycle `rd_valid_o=1`, `rd_pc_o=0xbfc00000`, `iq_count_o=1`.
- Four back-to-back writes with `rd_ready_i=0` (pc 0x0, 0x4, 0x8, 0xc) → `iq_stall_o=1` and `count=4`. A fifth write is held and not stored. Then `rd_ready_i=1` for one cycle: the head pc 0x0 pops, the stall clears the following cycle, and the fifth bundle enters.
- With the queue holding 2 entries, a simultaneous write and read over 10 cycles → `count` stays 2 and the pcs emerge in order with no gaps.
- With the queue holding 3 entries, `flush_i=1` together with `wr_valid_i=1` → next cycle `rd_valid_o=0`, `count=0`, and the flushed-cycle bundle is absent.
- `DEPTH=4`, 9 writes interleaved with reads → pointers wrap past 3 and all 9 pcs appear in order with the correct `inslot` and `excs` (include `wr_has_exc_i=1` with `excs[1]=1` for pc 0x2).
- `IQ_BYPASS_EN` defined, empty queue, write pc=0x80000000 with `rd_ready_i=1` → `rd_valid_o=1` and `rd_pc_o=0x80000000` in the same cycle, with `count` remaining 0.

Source files
------------

// File: rtl/if_inst_queue_pkg.sv
// if_inst_queue_pkg: shared bundle layout for the fetch->decode instruction queue.
// Holds the ExcE_W define, the bundle width and the IQ_* field offset macros.
// Optional feature macro used by the queue: IQ_BYPASS_EN.
`ifndef IF_INST_QUEUE_DEFS
`define IF_INST_QUEUE_DEFS
`define ExcE_W 8
// Bundle layout, LSB first: excs | has_exc | inslot | inst | pc
`define IQ_EXC_LSB 0
`define IQ_HASEXC_BIT(w) (w)
`define IQ_INSLOT_BIT(w) ((w) + 1)
`define IQ_INST_LSB(w) ((w) + 2)
`define IQ_PC_LSB(w) ((w) + 34)
`endif

package if_inst_queue_pkg;

  localparam int unsigned IQ_PC_W     = 32;
  localparam int unsigned IQ_INST_W   = 32;
  localparam int unsigned IQ_BUNDLE_W = IQ_PC_W + IQ_INST_W + 1 + 1 + `ExcE_W;

  // Bundle width for an arbitrary exception-vector width
  function automatic int unsigned iq_bundle_w(input int unsigned exc_w);
    return IQ_PC_W + IQ_INST_W + 1 + 1 + exc_w;
  endfunction

endpackage

// File: rtl/if_inst_queue_if.sv
// if_inst_queue_if: fetch write channel and decode read channel of the instruction queue.
// slave = the queue, master = fetch/decode side.
interface if_inst_queue_if #(
  parameter int unsigned EXC_W = `ExcE_W,
  parameter int unsigned CNT_W = 3
);
  logic             wr_valid_i;
  logic [31:0]      wr_pc_i;
  logic [31:0]      wr_inst_i;
  logic             wr_inslot_i;
  logic [EXC_W-1:0] wr_excs_i;
  logic             wr_has_exc_i;
  logic             iq_stall_o;
  logic             rd_valid_o;
  logic             rd_ready_i;
  logic [31:0]      rd_pc_o;
  logic [31:0]      rd_inst_o;
  logic             rd_inslot_o;
  logic [EXC_W-1:0] rd_excs_o;
  logic             rd_has_exc_o;
  logic [CNT_W-1:0] iq_count_o;

  modport slave (
    input  wr_valid_i, wr_pc_i, wr_inst_i, wr_inslot_i, wr_excs_i, wr_has_exc_i, rd_ready_i,
    output iq_stall_o, rd_valid_o, rd_pc_o, rd_inst_o, rd_inslot_o, rd_excs_o, rd_has_exc_o,
           iq_count_o
  );

  modport master (
    output wr_valid_i, wr_pc_i, wr_inst_i, wr_inslot_i, wr_excs_i, wr_has_exc_i, rd_ready_i,
    input  iq_stall_o, rd_valid_o, rd_pc_o, rd_inst_o, rd_inslot_o, rd_excs_o, rd_has_exc_o,
           iq_count_o
  );
endinterface

// File: rtl/if_inst_queue_iq_ram.sv
// iq_ram: DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port.
// Storage is intentionally not reset; occupancy tracking in the queue masks stale entries.
module iq_ram #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 74
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Asynchronous read port
  assign rdata = mem[raddr];

endmodule

// File: rtl/if_inst_queue.sv
// if_inst_queue: circular instruction queue between fetch and decode.
// Optional macro IQ_BYPASS_EN: an empty queue hands a fetch bundle straight to decode.
module if_inst_queue
  import if_inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned EXC_W = `ExcE_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  if_inst_queue_if.slave  iq
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned BUNDLE_W = iq_bundle_w(EXC_W);

  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic                empty;
  logic                byp;
  logic                wf;
  logic                rf;
  logic                rd_valid;
  logic [BUNDLE_W-1:0] wr_bundle;
  logic [BUNDLE_W-1:0] head_bundle;
  logic [BUNDLE_W-1:0] rd_bundle;

  assign wr_bundle = {iq.wr_pc_i, iq.wr_inst_i, iq.wr_inslot_i, iq.wr_has_exc_i, iq.wr_excs_i};

  iq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (BUNDLE_W)
  ) u_ram (
    .clk   (clk),
    .we    (wf),
    .waddr (tail),
    .wdata (wr_bundle),
    .raddr (head),
    .rdata (head_bundle)
  );

  // Fire conditions; flush kills both sides, a bypassed bundle is never enqueued
  always_comb begin
    full  = (count == CNT_W'(DEPTH));
    empty = (count == '0);
`ifdef IQ_BYPASS_EN
    byp   = empty & iq.wr_valid_i & iq.rd_ready_i & ~flush_i;
`else
    byp   = 1'b0;
`endif
    wf    = iq.wr_valid_i & ~full & ~flush_i & ~byp;
    rf    = ~empty & iq.rd_ready_i & ~flush_i;
  end

  // Pointer and occupancy registers; reset and flush both drop every entry
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wf) tail <= tail + PTR_W'(1);
      if (rf) head <= head + PTR_W'(1);
      case ({wf, rf})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head bundle selection, bypass mux and zeroing while not valid
  always_comb begin
    rd_valid  = ~empty;
    rd_bundle = head_bundle;
`ifdef IQ_BYPASS_EN
    if (empty) begin
      rd_valid  = iq.wr_valid_i;
      rd_bundle = wr_bundle;
    end
`endif
    if (!rd_valid) rd_bundle = '0;
  end

  assign iq.iq_stall_o   = full;
  assign iq.iq_count_o   = count;
  assign iq.rd_valid_o   = rd_valid;
  assign iq.rd_pc_o      = rd_bundle[`IQ_PC_LSB(EXC_W) +: 32];
  assign iq.rd_inst_o    = rd_bundle[`IQ_INST_LSB(EXC_W) +: 32];
  assign iq.rd_inslot_o  = rd_bundle[`IQ_INSLOT_BIT(EXC_W)];
  assign iq.rd_has_exc_o = rd_bundle[`IQ_HASEXC_BIT(EXC_W)];
  assign iq.rd_excs_o    = rd_bundle[`IQ_EXC_LSB +: EXC_W];

endmodule

// File: tb/tb_if_inst_queue.sv
// tb_if_inst_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_if_inst_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned EXC_W = `ExcE_W;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
`ifdef IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic             inslot;
    logic             hexc;
    logic [EXC_W-1:0] excs;
  } bundle_t;

  logic clk;
  logic rst;
  logic flush;

  if_inst_queue_if #(.EXC_W(EXC_W), .CNT_W(CNT_W)) iq ();

  if_inst_queue #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .iq      (iq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bundle_t     mq[$];
  bit          model_ok = 1'b0;
  bit          last_wf  = 1'b0;
  bit          capture  = 1'b0;
  logic [31:0] popped[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit wv, input logic [31:0] pc, input logic [31:0] inst,
                       input bit inslot, input bit hexc, input logic [EXC_W-1:0] excs,
                       input bit rr, input bit fl, input bit r);
    iq.wr_valid_i   = wv;
    iq.wr_pc_i      = pc;
    iq.wr_inst_i    = inst;
    iq.wr_inslot_i  = inslot;
    iq.wr_has_exc_i = hexc;
    iq.wr_excs_i    = excs;
    iq.rd_ready_i   = rr;
    flush           = fl;
    rst             = r;
  endtask

  // Compare DUT outputs with the model mid-cycle
  task automatic sample();
    bundle_t exp_b;
    bit      exp_v;
    @(negedge clk);
    if (model_ok) begin
      exp_b = '0;
      exp_v = 1'b0;
      if (mq.size() != 0) begin
        exp_v = 1'b1;
        exp_b = mq[0];
      end else if (BYP && iq.wr_valid_i) begin
        exp_v = 1'b1;
        exp_b = '{iq.wr_pc_i, iq.wr_inst_i, iq.wr_inslot_i, iq.wr_has_exc_i, iq.wr_excs_i};
      end
      chk("rd_valid", 64'(iq.rd_valid_o), 64'(exp_v));
      chk("rd_pc", 64'(iq.rd_pc_o), 64'(exp_b.pc));
      chk("rd_inst", 64'(iq.rd_inst_o), 64'(exp_b.inst));
      chk("rd_inslot", 64'(iq.rd_inslot_o), 64'(exp_b.inslot));
      chk("rd_has_exc", 64'(iq.rd_has_exc_o), 64'(exp_b.hexc));
      chk("rd_excs", 64'(iq.rd_excs_o), 64'(exp_b.excs));
      chk("stall", 64'(iq.iq_stall_o), 64'(mq.size() == DEPTH));
      chk("count", 64'(iq.iq_count_o), 64'(mq.size()));
      if (capture && iq.rd_valid_o && iq.rd_ready_i && !flush && !rst) popped.push_back(iq.rd_pc_o);
    end
  endtask

  // Advance one clock edge and apply the queue rules to the model
  task automatic tick();
    bit full;
    bit bypass;
    @(posedge clk);
    last_wf = 1'b0;
    if (rst) begin
      mq.delete();
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (flush) begin
        mq.delete();
      end else begin
        full   = (mq.size() == DEPTH);
        bypass = BYP && (mq.size() == 0) && iq.wr_valid_i && iq.rd_ready_i;
        if (mq.size() != 0 && iq.rd_ready_i) void'(mq.pop_front());
        if (iq.wr_valid_i && !full && !bypass) begin
          mq.push_back('{iq.wr_pc_i, iq.wr_inst_i, iq.wr_inslot_i, iq.wr_has_exc_i, iq.wr_excs_i});
          last_wf = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic step(input bit wv, input logic [31:0] pc, input bit rr, input bit fl);
    drive(wv, pc, ~pc, 1'b0, 1'b0, '0, rr, fl, 1'b0);
    sample();
    tick();
  endtask

  initial begin
    int cyc;
    int i;
    // Reset
    drive(1'b1, 32'hdead_beef, 32'h1234_5678, 1'b1, 1'b1, '1, 1'b1, 1'b0, 1'b1);
    sample();
    tick();
    sample();
    tick();
    drive(1'b0, 32'hffff_ffff, 32'hffff_ffff, 1'b1, 1'b1, '1, 1'b0, 1'b0, 1'b0);
    sample();
    chk("rst_valid", 64'(iq.rd_valid_o), 64'd0);
    chk("rst_count", 64'(iq.iq_count_o), 64'd0);
    chk("rst_stall", 64'(iq.iq_stall_o), 64'd0);
    chk("rst_pc", 64'(iq.rd_pc_o), 64'd0);
    tick();

    // First bundle after reset
    drive(1'b1, 32'hbfc0_0000, 32'h3c1d_8000, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    sample();
    tick();
    step(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    sample();
    chk("tp1_valid", 64'(iq.rd_valid_o), 64'd1);
    chk("tp1_pc", 64'(iq.rd_pc_o), 64'hbfc0_0000);
    chk("tp1_inst", 64'(iq.rd_inst_o), 64'h3c1d_8000);
    chk("tp1_count", 64'(iq.iq_count_o), 64'd1);
    tick();
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Fill to full, hold a fifth write, pop one, fifth enters
    for (int k = 0; k < 4; k++) step(1'b1, 32'(4 * k), 1'b0, 1'b0);
    step(1'b1, 32'h10, 1'b0, 1'b0);
    chk("tp2_held", 64'(last_wf), 64'd0);
    drive(1'b1, 32'h10, ~32'h10, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    sample();
    chk("tp2_stall", 64'(iq.iq_stall_o), 64'd1);
    chk("tp2_head", 64'(iq.rd_pc_o), 64'h0);
    tick();
    drive(1'b1, 32'h10, ~32'h10, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    sample();
    chk("tp2_unstall", 64'(iq.iq_stall_o), 64'd0);
    chk("tp2_cnt3", 64'(iq.iq_count_o), 64'd3);
    tick();
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Sustained write+read at occupancy 2
    step(1'b1, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'h104, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h108 + 32'(4 * k), 32'(k), 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      sample();
      chk("tp3_count", 64'(iq.iq_count_o), 64'd2);
      chk("tp3_pc", 64'(iq.rd_pc_o), 64'(32'h100 + 32'(4 * k)));
      tick();
    end
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Flush with a concurrent write
    for (int k = 0; k < 3; k++) step(1'b1, 32'h200 + 32'(k), 1'b0, 1'b0);
    step(1'b1, 32'h2ff, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    sample();
    chk("tp4_valid", 64'(iq.rd_valid_o), 64'd0);
    chk("tp4_count", 64'(iq.iq_count_o), 64'd0);
    tick();

    // Nine writes interleaved with reads, pointers wrap
    capture = 1'b1;
    i = 0;
    cyc = 0;
    while ((i < 9 || mq.size() != 0) && cyc < 60) begin
      drive(i < 9, 32'(i), 32'h1000 + 32'(i), (i % 2) == 1, i == 2,
            (i == 2) ? EXC_W'(2) : EXC_W'(0), (cyc % 2) == 1, 1'b0, 1'b0);
      sample();
      tick();
      if (last_wf || (BYP && i < 9 && iq.rd_ready_i && iq.wr_valid_i && !iq.iq_stall_o
                      && mq.size() == 0 && popped.size() == i + 1)) i++;
      cyc++;
    end
    capture = 1'b0;
    chk("tp5_npop", 64'(popped.size()), 64'd9);
    for (int k = 0; k < 9; k++) begin
      chk("tp5_order", (k < popped.size()) ? 64'(popped[k]) : 64'hffff_ffff, 64'(k));
    end

    // Empty-queue write with decode ready
    drive(1'b1, 32'h8000_0000, 32'h0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    sample();
    chk("byp_valid", 64'(iq.rd_valid_o), 64'(BYP));
    chk("byp_pc", 64'(iq.rd_pc_o), BYP ? 64'h8000_0000 : 64'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    sample();
    chk("byp_count", 64'(iq.iq_count_o), BYP ? 64'd0 : 64'd1);
    tick();

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 9) < 6, $urandom, $urandom, 1'($urandom), 1'($urandom),
            EXC_W'($urandom), $urandom_range(0, 9) < 5, $urandom_range(0, 99) < 3,
            $urandom_range(0, 199) == 0);
      sample();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
